uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte-stream requesters. Packet-level round-robin:
//  a granted requester keeps the transmitter until it sends a byte flagged last, reaches
//  MAX_BURST bytes, or stays idle for IDLE_TIMEOUT cycles. Sits between the client blocks and
//  the single uart_tx instance.
// PARAMETERS
//  NUM_REQ       4    number of requesters, 2..8
//  MAX_BURST     16   max bytes per grant, 1..256
//  IDLE_TIMEOUT  64   cycles the granted requester may hold req_valid_i low before losing the grant, >=1
// PORTS
//  clk            in   1          system clock, all logic on posedge
//  resetn         in   1          asynchronous active-low reset
//  req_valid_i    in   NUM_REQ    requester i has a byte on req_data_i[8i+7:8i]
//  req_data_i     in   8*NUM_REQ  byte per requester
//  req_last_i     in   NUM_REQ    byte is the last of the packet
//  req_ready_o    out  NUM_REQ    one-cycle pulse: byte of requester i accepted
//  grant_o        out  NUM_REQ    one-hot current owner, 0 when none
//  tx_start_o     out  1          one-cycle pulse: transmitter starts sending tx_d_o
//  tx_d_o         out  8          byte to send, stable from tx_start_o until tx_done_i
//  tx_busy_i      in   1          transmitter busy
//  tx_done_i      in   1          one-cycle pulse: stop bit finished
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer selects requester 0 first, burst/timeout counters 0.
//  FSM states:
//   IDLE : no owner. If any req_valid_i, pick first set bit at/after rr pointer (wrapping) ->
//          grant_o set next cycle, go LOAD. Arbitration costs 1 cycle.
//   LOAD : owner's valid=1 and tx_busy_i=0 -> latch data into tx_d_o, pulse req_ready_o[owner]
//          and tx_start_o same cycle, burst_cnt+1, latch last flag, go SEND.
//          owner's valid=0 -> idle_cnt+1; idle_cnt reaching IDLE_TIMEOUT -> RELEASE.
//          tx_busy_i=1 -> wait, no counting.
//   SEND : wait for tx_done_i. Then: latched last=1 or burst_cnt==MAX_BURST -> RELEASE,
//          else idle_cnt=0, go LOAD.
//   RELEASE : grant_o=0, rr pointer = owner+1 mod NUM_REQ, burst_cnt=0, idle_cnt=0, go IDLE.
//  Latency: valid at IDLE -> tx_start_o 2 cycles later (IDLE, LOAD). Byte-to-byte gap within a
//  packet = transmitter frame time + 1 cycle.
//  Handshake: requester holds valid/data/last until its ready pulse; ready never pulses for a
//  non-owner; at most one ready bit set per cycle; ready and tx_start_o always coincide.
//  Non-owners' valid changes ignored while a grant is held. Owner dropping valid is legal.
//  tx_done_i outside SEND ignored. burst_cnt width clog2(MAX_BURST+1), no wrap; MAX_BURST=1
//  gives byte-level round robin.
//  Reset mid-operation: immediate return to reset state, tx_start_o/ready drop asynchronously;
//  a byte already started is abandoned (transmitter reset separately).
// TESTING
//  1 Reset: resetn low with all valids high -> grant_o=0, tx_start_o=0, req_ready_o=0; after
//    release requester 0 granted first.
//  2 Single packet: req 2 sends 0x11,0x22,0x33(last) -> three tx_start_o with tx_d_o 11,22,33
//    in order, each after the previous tx_done_i; grant_o=4'b0100 throughout then 0.
//  3 Round robin: all 4 requesters send 1-byte packets continuously -> grant order 0,1,2,3,0,...
//  4 Burst limit: MAX_BURST=4, req 1 sends 10 bytes no last while req 3 waits -> 4 bytes from 1,
//    then grant to 3, then 1 resumes.
//  5 Idle timeout: owner drops valid after 1st byte for IDLE_TIMEOUT cycles -> grant released,
//    next requester granted; drop for IDLE_TIMEOUT-1 then resume -> grant kept.
//  6 Busy/reset: tx_busy_i held high in LOAD -> no start until low; resetn pulse mid SEND ->
//    outputs 0 at once, next grant from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin sharing of one UART transmitter among NUM_REQ byte streams.
// An owner keeps the transmitter until a last byte, MAX_BURST bytes, or IDLE_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 tx_start_o,
    output logic [7:0]           tx_d_o,
    input  logic                 tx_busy_i,
    input  logic                 tx_done_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d, rr_q, rr_d, pick;
    logic [BW-1:0] burst_q, burst_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          last_q, last_d;
    logic [7:0]    tx_d_q, tx_d_d;
    logic          fire;
    logic [7:0]    data_a [NUM_REQ];
    logic [IW-1:0] cand [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
        assign data_a[k] = req_data_i[8*k +: 8];
        assign cand[k]   = IW'((int'(rr_q) + k) % NUM_REQ);
    end

    // Scan from farthest to nearest so the first valid at/after rr_q wins.
    always_comb begin
        pick = rr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_valid_i[cand[i]]) pick = cand[i];
    end

    assign fire        = (state_q == LOAD) && req_valid_i[owner_q] && !tx_busy_i;
    assign grant_o     = (state_q == LOAD || state_q == SEND) ? NUM_REQ'(1) << owner_q : '0;
    assign req_ready_o = fire ? grant_o : '0;
    assign tx_start_o  = fire;
    assign tx_d_o      = fire ? data_a[owner_q] : tx_d_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        idle_d  = idle_q;
        last_d  = last_q;
        tx_d_d  = tx_d_q;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    owner_d = pick;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (fire) begin
                    tx_d_d  = data_a[owner_q];
                    last_d  = req_last_i[owner_q];
                    burst_d = burst_q + BW'(1);
                    state_d = SEND;
                end else if (!tx_busy_i) begin
                    if (idle_q == TW'(IDLE_TIMEOUT - 1)) state_d = RELEASE;
                    else idle_d = idle_q + TW'(1);
                end
            end
            SEND: begin
                if (tx_done_i) begin
                    if (last_q || burst_q == BW'(MAX_BURST)) begin
                        state_d = RELEASE;
                    end else begin
                        idle_d  = '0;
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
                burst_d = '0;
                idle_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            burst_q <= '0;
            idle_q  <= '0;
            last_q  <= 1'b0;
            tx_d_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            idle_q  <= idle_d;
            last_q  <= last_d;
            tx_d_q  <= tx_d_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: requester and transmitter models around uart_tx_arbiter with a start-order scoreboard.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int T  = 8;
    localparam int F  = 5;

    logic           clk = 1'b0, resetn = 1'b0;
    logic [N-1:0]   req_valid_i = '0, req_last_i = '0;
    logic [8*N-1:0] req_data_i = '0;
    logic [N-1:0]   req_ready_o, grant_o;
    logic           tx_start_o, tx_busy_i = 1'b0, tx_done_i = 1'b0;
    logic [7:0]     tx_d_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(T)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
        .req_ready_o(req_ready_o), .grant_o(grant_o),
        .tx_start_o(tx_start_o), .tx_d_o(tx_d_o),
        .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i)
    );

    typedef struct {
        int         grp;
        int         req;
        logic [7:0] d;
        logic       last;
        logic [3:0] eg;
    } vec_t;

    vec_t        tbl [$];
    logic [8:0]  rq [N][$];
    logic [11:0] exp_q [$];
    logic [11:0] e_m;
    int          checks = 0, errors = 0;
    logic [N-1:0] seen_ready = '0;
    logic        seen_start = 1'b0, busy_m = 1'b0, force_busy = 1'b0, hold_arm = 1'b0;
    int          cnt = 0, hold_req = 0, hold_len = 0, n = 0;
    int          hold_cnt [N] = '{default: 0};
    logic [7:0]  cur_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        rq[r].push_back({last, d});
        exp_q.push_back({4'(1 << r), d});
    endtask

    task automatic load_grp(input int g);
        foreach (tbl[k])
            if (tbl[k].grp == g) begin
                rq[tbl[k].req].push_back({tbl[k].last, tbl[k].d});
                exp_q.push_back({tbl[k].eg, tbl[k].d});
            end
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(exp_q.size() == 0 && grant_o == '0 && cnt == 0 && !tx_busy_i) && w < 3000);
        checks++;
        if (w >= 3000) begin
            errors++;
            $display("FAIL %s: timeout with %0d starts outstanding, grant=%b", name, exp_q.size(), grant_o);
            exp_q.delete();
            for (int i = 0; i < N; i++) rq[i].delete();
        end
    endtask

    // Requesters and transmitter are driven just after the edge from what was seen at the previous negedge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (seen_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (hold_cnt[i] > 0) hold_cnt[i]--;
        end
        tx_done_i = 1'b0;
        if (!resetn) begin
            cnt    = 0;
            busy_m = 1'b0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done_i = 1'b1;
                    busy_m    = 1'b0;
                    if (hold_arm) begin
                        hold_cnt[hold_req] = hold_len;
                        hold_arm = 1'b0;
                    end
                end
            end
            if (seen_start) begin
                cnt    = F;
                busy_m = 1'b1;
            end
        end
        tx_busy_i = busy_m | force_busy;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = (rq[i].size() > 0) && (hold_cnt[i] == 0);
            {req_last_i[i], req_data_i[8*i +: 8]} = (rq[i].size() > 0) ? rq[i][0] : 9'h0;
        end
    end

    always @(negedge clk) begin
        seen_ready = req_ready_o;
        seen_start = tx_start_o;
        if (resetn) begin
            if (tx_start_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: grant=%b d=%h expected no start", grant_o, tx_d_o);
                end else begin
                    e_m = exp_q.pop_front();
                    check("start", {15'd0, grant_o, tx_d_o, req_ready_o, tx_busy_i}, {15'd0, e_m, e_m[11:8], 1'b0});
                end
                cur_d = tx_d_o;
            end else if (req_ready_o != '0) begin
                checks++;
                errors++;
                $display("FAIL ready_no_start: ready=%b expected 0000", req_ready_o);
            end
            if (tx_done_i) check("tx_d_stable", {24'd0, tx_d_o}, {24'd0, cur_d});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{0, 0, 8'hA0, 1'b1, 4'b0001});
        tbl.push_back('{0, 1, 8'hA1, 1'b1, 4'b0010});
        tbl.push_back('{0, 2, 8'hA2, 1'b1, 4'b0100});
        tbl.push_back('{0, 3, 8'hA3, 1'b1, 4'b1000});
        tbl.push_back('{1, 2, 8'h11, 1'b0, 4'b0100});
        tbl.push_back('{1, 2, 8'h22, 1'b0, 4'b0100});
        tbl.push_back('{1, 2, 8'h33, 1'b1, 4'b0100});
        // Requester 2 was the last owner, so the pointer starts this round at 3.
        tbl.push_back('{2, 3, 8'hC3, 1'b1, 4'b1000});
        tbl.push_back('{2, 0, 8'hC0, 1'b1, 4'b0001});
        tbl.push_back('{2, 1, 8'hC1, 1'b1, 4'b0010});
        tbl.push_back('{2, 2, 8'hC2, 1'b1, 4'b0100});
        tbl.push_back('{2, 3, 8'hD3, 1'b1, 4'b1000});
        tbl.push_back('{2, 0, 8'hD0, 1'b1, 4'b0001});
        tbl.push_back('{2, 1, 8'hD1, 1'b1, 4'b0010});
        tbl.push_back('{2, 2, 8'hD2, 1'b1, 4'b0100});
        tbl.push_back('{2, 3, 8'hE3, 1'b1, 4'b1000});
        for (int i = 0; i < 10; i++) begin
            tbl.push_back('{3, 1, 8'(8'h10 + i), 1'b0, 4'b0010});
            if (i == 3) tbl.push_back('{3, 3, 8'h30, 1'b1, 4'b1000});
        end

        resetn = 1'b0;
        load_grp(0);
        repeat (4) @(negedge clk);
        check("reset_outputs", {23'd0, grant_o, tx_start_o, req_ready_o}, 32'd0);
        resetn = 1'b1;
        n = 0;
        while (grant_o == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_grant", {28'd0, grant_o}, 32'h1);
        wait_idle("reset_rr");

        load_grp(1);
        wait_idle("single_packet");
        check("grant_released", {28'd0, grant_o}, 32'd0);

        load_grp(2);
        wait_idle("round_robin");

        load_grp(3);
        wait_idle("burst_limit");

        hold_req = 0;
        hold_len = T;
        hold_arm = 1'b1;
        push(0, 8'h50, 1'b0);
        push(0, 8'h51, 1'b1);
        push(1, 8'h60, 1'b1);
        wait_idle("idle_kept");

        hold_req = 2;
        hold_len = T + 1;
        hold_arm = 1'b1;
        push(2, 8'h52, 1'b0);
        push(3, 8'h70, 1'b1);
        push(2, 8'h53, 1'b1);
        wait_idle("idle_release");

        force_busy = 1'b1;
        push(3, 8'h80, 1'b1);
        repeat (6) @(negedge clk);
        check("busy_hold", {27'd0, grant_o, tx_start_o}, {27'd0, 4'b1000, 1'b0});
        force_busy = 1'b0;
        wait_idle("busy_release");

        push(1, 8'h90, 1'b1);
        n = 0;
        while (!tx_start_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_started", {31'd0, tx_start_o}, 32'd1);
        repeat (2) @(negedge clk);
        check("grant_in_send", {28'd0, grant_o}, 32'h2);
        #2 resetn = 1'b0;
        #1 check("reset_async", {15'd0, grant_o, tx_start_o, req_ready_o, tx_d_o}, 32'd0);
        push(0, 8'hC5, 1'b1);
        push(2, 8'hB5, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        wait_idle("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
